// File: rtl/instr_fetch_unit_pkg.sv
// Shared ISA and fetch definitions: opcode constants, opcode field position, fetch FSM encoding.
package instr_fetch_unit_pkg;

    localparam logic [5:0] OPC_JMP = 6'b001001;
    localparam logic [5:0] OPC_BEQ = 6'b000111;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

    function automatic logic is_jmp(input logic [31:0] word);
        return word[OPC_MSB:OPC_LSB] == OPC_JMP;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_next.sv
// Combinational next-PC selection: redirect over predecoded jmp over wrap-increment, plus range check.
module fetch_pc_next
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 64
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_fetch,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_target,
    input  logic              i_jmp,
    input  logic [ADDR_W-1:0] i_jmp_target,
    output logic [ADDR_W-1:0] o_pc_next,
    output logic              o_pc_load,
    output logic              o_fault,
    output logic              o_jmp_taken
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    logic [ADDR_W:0]   w_inc;
    logic [ADDR_W-1:0] w_wrap;
    logic [ADDR_W-1:0] w_target;
    logic              w_oob;

    assign w_inc    = {1'b0, i_pc} + 1'b1;
    assign w_wrap   = (w_inc == DEPTH) ? '0 : w_inc[ADDR_W-1:0];
    assign w_target = i_redirect_valid ? i_redirect_target : i_jmp_target;
    assign w_oob    = {1'b0, w_target} >= DEPTH;

    // An out-of-range target never reaches the PC; it only raises the fault.
    always_comb begin
        o_pc_next   = i_pc;
        o_pc_load   = 1'b0;
        o_fault     = 1'b0;
        o_jmp_taken = 1'b0;
        if (i_redirect_valid) begin
            if (w_oob) begin
                o_fault = 1'b1;
            end else begin
                o_pc_next = w_target;
                o_pc_load = 1'b1;
            end
        end else if (i_fetch) begin
            if (i_jmp) begin
                o_jmp_taken = 1'b1;
                if (w_oob) begin
                    o_fault = 1'b1;
                end else begin
                    o_pc_next = w_target;
                    o_pc_load = 1'b1;
                end
            end else begin
                o_pc_next = w_wrap;
                o_pc_load = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the PC, reads instruction memory, hands words to decode via valid/ready.
// Optional jmp predecode in the fetch stage is enabled with `define FETCH_JMP_PREDECODE_EN.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              ADDR_W    = 8,
    parameter int              MEM_DEPTH = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              memread,
    output logic [ADDR_W-1:0] address,
    input  logic [31:0]       readdata,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              fault,
    output logic [1:0]        dbg_state
);

    // Handshake: a word transfers to decode on any edge where inst_valid && inst_ready;
    // inst/inst_pc are stable while inst_valid is high and inst_ready is low.

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_inst;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_inst_valid;
    logic              r_fault;

    logic              w_can_load;
    logic              w_redirect;
    logic              w_is_jmp;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_pc_load;
    logic              w_oob;
    logic              w_jmp_taken;

    assign w_can_load = !r_inst_valid || inst_ready;
    assign memread    = (r_state == ST_RUN) && enable && w_can_load && !redirect_valid;
    assign w_redirect = redirect_valid && (r_state != ST_HALT);

`ifdef FETCH_JMP_PREDECODE_EN
    assign w_is_jmp = is_jmp(readdata);
`else
    assign w_is_jmp = 1'b0;
`endif

    fetch_pc_next #(
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_pc_next (
        .i_pc              (r_pc),
        .i_fetch           (memread),
        .i_redirect_valid  (w_redirect),
        .i_redirect_target (redirect_target),
        .i_jmp             (w_is_jmp),
        .i_jmp_target      (readdata[ADDR_W-1:0]),
        .o_pc_next         (w_pc_next),
        .o_pc_load         (w_pc_load),
        .o_fault           (w_oob),
        .o_jmp_taken       (w_jmp_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pc_load) r_pc <= w_pc_next;
                    if (w_oob) r_fault <= 1'b1;
                    if (enable) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_pc_load) r_pc <= w_pc_next;
                    if (w_oob) begin
                        r_fault <= 1'b1;
                        r_state <= ST_HALT;
                    end
                    // A redirect flushes the held word even if decode takes it this cycle.
                    if (redirect_valid) begin
                        r_inst_valid <= 1'b0;
                    end else if (memread) begin
                        if (w_jmp_taken) begin
                            r_inst_valid <= 1'b0;
                        end else begin
                            r_inst       <= readdata;
                            r_inst_pc    <= r_pc;
                            r_inst_valid <= 1'b1;
                        end
                    end else if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                    end
                end
                ST_HALT: begin
                    r_inst_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign address    = r_pc;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = r_inst_valid;
    assign fault      = r_fault;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps plus random traffic against a cycle-level reference model.
module tb_instr_fetch_unit;

    localparam int ADDR_W    = 8;
    localparam int MEM_DEPTH = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              inst_ready = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_target = '0;
    logic              memread;
    logic [ADDR_W-1:0] address;
    logic [31:0]       readdata;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              fault;
    logic [1:0]        dbg_state;

    logic [31:0] mem [MEM_DEPTH];

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = idle, 1 = running, 2 = halted
    int          m_state;
    int          m_pc;
    int          m_inst_pc;
    logic [31:0] m_inst;
    bit          m_valid;
    bit          m_fault;

    always #5 clk = ~clk;

    assign readdata = mem[address[5:0]];

    instr_fetch_unit #(
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH),
        .RESET_PC  (8'd0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .memread         (memread),
        .address         (address),
        .readdata        (readdata),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fault           (fault),
        .dbg_state       (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_pc      = 0;
        m_inst_pc = 0;
        m_inst    = 32'h0;
        m_valid   = 1'b0;
        m_fault   = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit rdy, input bit rv, input int rt, input bit fetch);
        logic [31:0] word;
        int          jt;
        if (m_state == 0) begin
            if (rv) begin
                if (rt < MEM_DEPTH) m_pc = rt;
                else m_fault = 1'b1;
            end
            if (en) m_state = 1;
        end else if (m_state == 1) begin
            if (rv) begin
                m_valid = 1'b0;
                if (rt < MEM_DEPTH) m_pc = rt;
                else begin
                    m_fault = 1'b1;
                    m_state = 2;
                end
            end else if (fetch) begin
                word = mem[m_pc];
`ifdef FETCH_JMP_PREDECODE_EN
                if (word[31:26] == 6'b001001) begin
                    jt      = int'(word[7:0]);
                    m_valid = 1'b0;
                    if (jt < MEM_DEPTH) m_pc = jt;
                    else begin
                        m_fault = 1'b1;
                        m_state = 2;
                    end
                end else begin
`endif
                    m_inst    = word;
                    m_inst_pc = m_pc;
                    m_valid   = 1'b1;
                    m_pc      = (m_pc + 1) % MEM_DEPTH;
`ifdef FETCH_JMP_PREDECODE_EN
                end
`endif
            end else if (rdy) begin
                m_valid = 1'b0;
            end
        end
        jt = 0;
    endtask

    // Entered at posedge+1; drives inputs, checks at the falling edge, advances the model at the rising edge.
    task automatic cycle(input bit en, input bit rdy, input bit rv, input int rt);
        bit exp_mr;
        enable          = en;
        inst_ready      = rdy;
        redirect_valid  = rv;
        redirect_target = rt[ADDR_W-1:0];
        @(negedge clk);
        exp_mr = (m_state == 1) && en && (!m_valid || rdy) && !rv;
        chk("memread", 32'(memread), 32'(exp_mr));
        chk("address", 32'(address), m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(m_valid));
        chk("inst", inst, m_inst);
        chk("inst_pc", 32'(inst_pc), m_inst_pc);
        chk("fault", 32'(fault), 32'(m_fault));
        @(posedge clk);
        model_step(en, rdy, rv, rt, exp_mr);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            w = $urandom;
            if (w[31:26] == 6'b001001) w[31:26] = 6'b000111;
            mem[i] = w;
        end
        mem[0] = 32'h0BBC0000;
        mem[9] = 32'h24000000;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_memread", 32'(memread), 32'h0);
        chk("rst_address", 32'(address), 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        rst_n = 1'b1;

        // Start up and stream sequential words
        repeat (2) cycle(1, 1, 0, 0);
        chk("first_word", inst, 32'h0BBC0000);
        chk("first_pc", 32'(inst_pc), 32'h0);
        repeat (2) cycle(1, 1, 0, 0);
        chk("pc2", 32'(inst_pc), 32'h2);

        // Decode stall for three cycles
        repeat (3) cycle(1, 0, 0, 0);
        chk("stall_hold_pc", 32'(inst_pc), 32'h2);
        cycle(1, 1, 0, 0);
        chk("after_stall_pc", 32'(inst_pc), 32'h3);

        // Redirect while stalled on inst_pc=4
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 8);
        chk("redirect_bubble", 32'(inst_valid), 32'h0);
        cycle(1, 1, 0, 0);
        chk("redirect_pc8", 32'(inst_pc), 32'h8);
        repeat (4) cycle(1, 1, 0, 0);

        // Drain with enable low
        repeat (2) cycle(0, 1, 0, 0);

        // Wrap past the last implemented word
        cycle(1, 1, 1, 62);
        repeat (4) cycle(1, 1, 0, 0);

        // Redirect while idle is not possible here; exercise random traffic
        repeat (400) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                           $urandom_range(0, 9) == 0, $urandom_range(0, MEM_DEPTH - 1));

        // Out-of-range redirect halts; later redirects are ignored
        cycle(1, 1, 1, 70);
        repeat (3) cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 5);
        repeat (2) cycle(1, 0, 0, 0);

        // Asynchronous reset in the middle of a HALT cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("halt_rst_fault", 32'(fault), 32'h0);
        chk("halt_rst_address", 32'(address), 32'h0);
        chk("halt_rst_memread", 32'(memread), 32'h0);
        chk("halt_rst_valid", 32'(inst_valid), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Redirect while idle, then run from the new PC
        cycle(0, 1, 1, 20);
        repeat (5) cycle(1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
